// File: rtl/cc_campaign_ctrl.sv
// Fault-injection campaign sequencer for CC: one golden run, then one single-pulse fault run per cycle.
// Define CC_CAMPAIGN_PATTERN_EN to drive cc_enable from a reseeded 8-bit LFSR instead of constant 1.
module cc_campaign_ctrl #(
  parameter int RUN_LEN    = 16,
  parameter int RST_CYCLES = 2
`ifdef CC_CAMPAIGN_PATTERN_EN
  ,
  parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] cc_out_i,
  output logic       cc_reset_o,
  output logic       cc_enable_o,
  output logic       cc_fp_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] golden_o,
  output logic [7:0] fail_count_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [7:0] evt_cycle_o,
  output logic [7:0] evt_value_o
);

  typedef enum logic [2:0] {IDLE, RST, RUN, CHECK, REPORT, DONE} state_e;

  localparam logic [7:0] RUN_LAST = 8'(RUN_LEN - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_e     state_q;
  logic       golden_phase_q;
  logic [7:0] inj_idx_q;
  logic [7:0] cyc_q;
  logic [7:0] golden_q;
  logic [7:0] fail_count_q;
  logic [7:0] evt_cycle_q;
  logic [7:0] evt_value_q;
  logic       cc_reset_q;
  logic       cc_enable_q;
  logic       cc_fp_q;
  logic       busy_q;
  logic       done_q;
  logic       evt_valid_q;

  logic [7:0] cyc_d;
  logic       rst_last;
  logic       run_last;
  logic       inj_last;
  logic       en_first;
  logic       en_next;

  assign cyc_d    = cyc_q + 8'd1;
  assign rst_last = (cyc_q == RST_LAST);
  assign run_last = (cyc_q == RUN_LAST);
  assign inj_last = (inj_idx_q == RUN_LAST);

`ifdef CC_CAMPAIGN_PATTERN_EN
  // Reloaded on the last RST cycle so every run replays the same enable sequence.
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign en_first = LFSR_SEED[0];
  assign en_next  = lfsr_d[0];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == RST && rst_last) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == RUN) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign en_first = 1'b1;
  assign en_next  = 1'b1;
`endif

  // Outputs are loaded with the values of the state being entered, so cc_fp lines up with RUN cycle inj_idx.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      golden_phase_q <= 1'b0;
      inj_idx_q      <= 8'd0;
      cyc_q          <= 8'd0;
      golden_q       <= 8'd0;
      fail_count_q   <= 8'd0;
      evt_cycle_q    <= 8'd0;
      evt_value_q    <= 8'd0;
      cc_reset_q     <= 1'b1;
      cc_enable_q    <= 1'b0;
      cc_fp_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      evt_valid_q    <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      cc_enable_q <= 1'b0;
      cc_fp_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q        <= RST;
            golden_phase_q <= 1'b1;
            inj_idx_q      <= 8'd0;
            fail_count_q   <= 8'd0;
            cyc_q          <= 8'd0;
            busy_q         <= 1'b1;
          end
        end
        RST: begin
          if (rst_last) begin
            state_q     <= RUN;
            cyc_q       <= 8'd0;
            cc_reset_q  <= 1'b0;
            cc_enable_q <= en_first;
            cc_fp_q     <= !golden_phase_q && (inj_idx_q == 8'd0);
          end else begin
            cyc_q <= cyc_d;
          end
        end
        RUN: begin
          if (run_last) begin
            state_q <= CHECK;
          end else begin
            cyc_q       <= cyc_d;
            cc_enable_q <= en_next;
            cc_fp_q     <= !golden_phase_q && (inj_idx_q == cyc_d);
          end
        end
        CHECK: begin
          cc_reset_q <= 1'b1;
          if (golden_phase_q) begin
            golden_q       <= cc_out_i;
            golden_phase_q <= 1'b0;
            cyc_q          <= 8'd0;
            state_q        <= RST;
          end else if (cc_out_i != golden_q) begin
            evt_cycle_q <= inj_idx_q;
            evt_value_q <= cc_out_i;
            evt_valid_q <= 1'b1;
            state_q     <= REPORT;
            if (fail_count_q != 8'hFF) begin
              fail_count_q <= fail_count_q + 8'd1;
            end
          end else if (inj_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            inj_idx_q <= inj_idx_q + 8'd1;
            cyc_q     <= 8'd0;
            state_q   <= RST;
          end
        end
        REPORT: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            if (inj_last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              inj_idx_q <= inj_idx_q + 8'd1;
              cyc_q     <= 8'd0;
              state_q   <= RST;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cc_reset_o   = cc_reset_q;
  assign cc_enable_o  = cc_enable_q;
  assign cc_fp_o      = cc_fp_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign golden_o     = golden_q;
  assign fail_count_o = fail_count_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_cycle_o  = evt_cycle_q;
  assign evt_value_o  = evt_value_q;

endmodule

// File: tb/tb_cc_campaign_ctrl.sv
// Scoreboard bench for cc_campaign_ctrl driving a stub CC counter (RUN_LEN=4, RST_CYCLES=2).
// Stimulus queues expected events/results; one negedge monitor pops and compares them.
module tb_cc_campaign_ctrl;

  localparam int RUN_LEN    = 4;
  localparam int RST_CYCLES = 2;
  // Cycles from the cycle after start through DONE when no event is reported.
  localparam int MIN_LAT    = (RUN_LEN + 1) * (RST_CYCLES + RUN_LEN + 1) + 1;

  typedef struct {
    int cyc;
    int value;
  } evt_t;

  typedef struct {
    int golden;
    int failCount;
    int latency;
  } done_t;

  typedef struct {
    string name;
    int    actual;
    int    expected;
  } scalar_t;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       start    = 1'b0;
  logic       evtReady = 1'b1;
  logic       maskFp   = 1'b0;
  logic [7:0] ccOut    = 8'd0;
  logic       ccReset, ccEnable, ccFp, busy, done, evtValid;
  logic [7:0] golden, failCount, evtCycle, evtValue;

  int checks   = 0;
  int errors   = 0;
  int cycleCnt = 0;

  evt_t    expEvtQ[$];
  done_t   expDoneQ[$];
  scalar_t scalarQ[$];
  string   resetSnapQ[$];

  int         startCnt    = 0;
  int         runIdx      = 0;
  int         runCyc      = 0;
  int         fpCount     = 0;
  int         stallCnt    = 0;
  logic       prevCcReset = 1'b1;
  logic [7:0] enBits      = 8'd0;
  logic [7:0] goldenEn    = 8'd0;
  evt_t       evtHead;
  done_t      doneHead;
  scalar_t    sc;
  string      tag;

  cc_campaign_ctrl #(
    .RUN_LEN   (RUN_LEN),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .cc_out_i    (ccOut),
    .cc_reset_o  (ccReset),
    .cc_enable_o (ccEnable),
    .cc_fp_o     (ccFp),
    .busy_o      (busy),
    .done_o      (done),
    .golden_o    (golden),
    .fail_count_o(failCount),
    .evt_valid_o (evtValid),
    .evt_ready_i (evtReady),
    .evt_cycle_o (evtCycle),
    .evt_value_o (evtValue)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Stub CC: +1 per enabled cycle, +2 when a fault pulse lands (unless the fault is masked).
  always @(posedge clk) begin
    if (ccReset) ccOut <= 8'd0;
    else if (ccEnable) ccOut <= ccOut + ((ccFp && !maskFp) ? 8'd2 : 8'd1);
  end

  function automatic logic [7:0] expGoldenEn();
    logic [7:0] e = 8'd0;
`ifdef CC_CAMPAIGN_PATTERN_EN
    logic [7:0] l = 8'hA5;
    for (int i = 0; i < RUN_LEN; i++) begin
      e[i] = l[0];
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
`else
    for (int i = 0; i < RUN_LEN; i++) e[i] = 1'b1;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic maskIn, input logic readyIn);
    maskFp   = maskIn;
    evtReady = readyIn;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic pushFaultEvents(input int value);
    for (int i = 0; i < RUN_LEN; i++) expEvtQ.push_back('{cyc: i, value: value});
  endtask

  task automatic pushScalar(input string name, input int actual, input int expected);
    scalarQ.push_back('{name: name, actual: actual, expected: expected});
  endtask

  task automatic waitDone();
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    pushScalar("campaignEnds", int'(busy), 0);
    pushScalar("donePending", expDoneQ.size(), 0);
    tick();
  endtask

  // Monitor: drains queued requests, tracks runs/fp/enable, and scoreboards events and done.
  always @(negedge clk) begin
    while (scalarQ.size() > 0) begin
      sc = scalarQ.pop_front();
      checkOutput(sc.name, sc.actual, sc.expected);
    end
    while (resetSnapQ.size() > 0) begin
      tag = resetSnapQ.pop_front();
      checkOutput({tag, "CcReset"}, ccReset, 1);
      checkOutput({tag, "CcEnable"}, ccEnable, 0);
      checkOutput({tag, "CcFp"}, ccFp, 0);
      checkOutput({tag, "Busy"}, busy, 0);
      checkOutput({tag, "Done"}, done, 0);
      checkOutput({tag, "EvtValid"}, evtValid, 0);
      checkOutput({tag, "Golden"}, golden, 0);
      checkOutput({tag, "FailCount"}, failCount, 0);
      checkOutput({tag, "EvtCycle"}, evtCycle, 0);
      checkOutput({tag, "EvtValue"}, evtValue, 0);
    end
    if (reset) begin
      prevCcReset = 1'b1;
      runCyc      = 0;
    end else begin
      if (start && !busy) begin
        startCnt = cycleCnt;
        runIdx   = -1;
        fpCount  = 0;
        stallCnt = 0;
      end
      if (!ccReset) begin
        if (prevCcReset) begin
          runIdx++;
          runCyc = 0;
          enBits = 8'd0;
        end else begin
          runCyc++;
        end
        if (runCyc < 8) enBits[runCyc] = ccEnable;
        if (ccFp) begin
          fpCount++;
          checkOutput("fpRunCycle", runCyc, runIdx - 1);
        end
      end else begin
        if (ccFp) checkOutput("fpWhileCcReset", 1, 0);
        if (!prevCcReset && runCyc == RUN_LEN) begin
          if (runIdx == 0) begin
            goldenEn = enBits;
            checkOutput("goldenEnSeq", enBits, expGoldenEn());
          end else begin
            checkOutput("faultEnSeq", enBits, goldenEn);
          end
        end
      end
      prevCcReset = ccReset;

      if (evtValid) begin
        if (expEvtQ.size() == 0) begin
          checkOutput("unexpectedEvt", 1, 0);
        end else begin
          evtHead = expEvtQ[0];
          checkOutput("evtCycle", evtCycle, evtHead.cyc);
          checkOutput("evtValue", evtValue, evtHead.value);
          checkOutput("evtCcReset", ccReset, 1);
          checkOutput("evtCcFp", ccFp, 0);
          if (evtReady) void'(expEvtQ.pop_front());
          else stallCnt++;
        end
      end

      if (done) begin
        if (expDoneQ.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          doneHead = expDoneQ.pop_front();
          checkOutput("golden", golden, doneHead.golden);
          checkOutput("failCount", failCount, doneHead.failCount);
          checkOutput("doneLatency", cycleCnt - startCnt, doneHead.latency);
          checkOutput("fpCount", fpCount, RUN_LEN);
          checkOutput("evtLeftover", expEvtQ.size(), 0);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) tick();
    resetSnapQ.push_back("rst");
    tick();
    reset = 1'b0;
    tick();
    resetSnapQ.push_back("idle");
    tick();

    // Baseline, with a start pulse mid-campaign that must be ignored.
    $display("[TB] baseline campaign");
    pushFaultEvents(5);
    expDoneQ.push_back('{golden: 4, failCount: 4, latency: MIN_LAT + RUN_LEN});
    applyStimulus(1'b0, 1'b1);
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone();

    $display("[TB] fault-masking stub");
    expDoneQ.push_back('{golden: 4, failCount: 0, latency: MIN_LAT});
    applyStimulus(1'b1, 1'b1);
    waitDone();

    $display("[TB] backpressure on first event");
    pushFaultEvents(5);
    expDoneQ.push_back('{golden: 4, failCount: 4, latency: MIN_LAT + RUN_LEN + 10});
    applyStimulus(1'b0, 1'b0);
    n = 0;
    while (!evtValid && n < 100) begin
      tick();
      n++;
    end
    pushScalar("bpEvtSeen", int'(evtValid), 1);
    repeat (10) tick();
    evtReady = 1'b1;
    waitDone();
    pushScalar("bpStallCycles", stallCnt, 10);
    tick();

    // Reset lands in RUN cycle 1 of the fault run with inj_idx=1 (cycle 19 after start).
    $display("[TB] reset mid-campaign");
    expEvtQ.push_back('{cyc: 0, value: 5});
    applyStimulus(1'b0, 1'b1);
    repeat (18) tick();
    pushScalar("preRstFailCount", int'(failCount), 1);
    pushScalar("preRstCcFp", int'(ccFp), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    resetSnapQ.push_back("midRst");
    tick();
    pushScalar("midRstEvtQ", expEvtQ.size(), 0);
    tick();

    $display("[TB] campaign after reset");
    pushFaultEvents(5);
    expDoneQ.push_back('{golden: 4, failCount: 4, latency: MIN_LAT + RUN_LEN});
    applyStimulus(1'b0, 1'b1);
    waitDone();
    pushScalar("finalEvtQ", expEvtQ.size(), 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
